// File: rtl/gpio_cfg_serializer.sv
// Purpose: PL-side transmitter for the 16-bit GPIO configuration bus; shifts a word MSB-first
//          on sdata (bit 0) against one serial clock line, and owns the level and trigger lines.
// Latency: accept at edge 0 -> first bit on the bus in cycle 1; idle again at cycle 2+nbits*2*HALF.
// Backpressure: cmd_ready is high only in IDLE; rejected commands pulse err and keep cmd_ready high.
//
// Ports:
//   clk, rst                 fabric clock, synchronous active-high reset
//   cmd_valid/cmd_ready      serial write handshake
//   cmd_sel, cmd_data,       target clock line index, word to shift, bit count (1..DATA_W)
//   cmd_nbits
//   lvl_we, lvl_data         write level lines (bits 5, 13, 14, 15)
//   trig_req                 start/restart the trigger pulse on bit 6
//   gpio_out                 registered GPIO bus
//   busy, err                FSM not idle / one-cycle command-rejected pulse
module gpio_cfg_serializer #(
  parameter int GPIO_W      = 16,
  parameter int DATA_W      = 32,
  parameter int HALF        = 2,
  parameter int TRIG_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [5:0]        cmd_nbits,
  input  logic              lvl_we,
  input  logic [GPIO_W-1:0] lvl_data,
  input  logic              trig_req,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              busy,
  output logic              err
);

  localparam int PH_W  = $clog2(HALF + 1);
  localparam int TR_W  = $clog2(TRIG_CYCLES + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam int SEL_W = $clog2(GPIO_W);
  localparam logic [GPIO_W-1:0] LVL_MASK = GPIO_W'(16'hE020);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, DONE} state_t;

  state_t              state_q, state_nxt;
  logic [PH_W-1:0]     ph_q, ph_nxt;
  logic [5:0]          idx_q, idx_nxt;
  logic [DATA_W-1:0]   word_q, word_nxt;
  logic [SEL_W-1:0]    sel_q, sel_nxt;
  logic [TR_W-1:0]     trig_q, trig_nxt;
  logic [GPIO_W-1:0]   lvl_q, lvl_nxt, gpio_nxt;
  logic                ready_q, err_nxt, accept, sel_ok, cmd_ok, ph_last;

  assign cmd_ready = ready_q;
  assign busy      = (state_q != IDLE);
  assign accept    = cmd_valid && ready_q;
  assign ph_last   = (ph_q == PH_W'(HALF));

  // Only the serial clock lines are legal targets.
  always_comb begin
    sel_ok = 1'b0;
    case (cmd_sel)
      8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12: sel_ok = 1'b1;
      default: sel_ok = 1'b0;
    endcase
  end

  assign cmd_ok = sel_ok && (cmd_nbits != 6'd0) && (cmd_nbits <= 6'(DATA_W));

  // Shift FSM next state.
  always_comb begin
    state_nxt = state_q;
    ph_nxt    = ph_q;
    idx_nxt   = idx_q;
    word_nxt  = word_q;
    sel_nxt   = sel_q;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_ok) begin
            state_nxt = SETUP;
            ph_nxt    = PH_W'(1);
            idx_nxt   = cmd_nbits - 6'd1;
            word_nxt  = cmd_data;
            sel_nxt   = cmd_sel[SEL_W-1:0];
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        if (ph_last) begin
          state_nxt = HIGH;
          ph_nxt    = PH_W'(1);
        end else begin
          ph_nxt = ph_q + PH_W'(1);
        end
      end
      HIGH: begin
        if (ph_last) begin
          ph_nxt = PH_W'(1);
          if (idx_q == 6'd0) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx_q - 6'd1;
            state_nxt = SETUP;
          end
        end else begin
          ph_nxt = ph_q + PH_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Level and trigger lines run independently of the shift FSM.
  always_comb begin
    lvl_nxt = lvl_we ? (lvl_data & LVL_MASK) : lvl_q;
    if (trig_req) begin
      trig_nxt = TR_W'(TRIG_CYCLES);
    end else if (trig_q != '0) begin
      trig_nxt = trig_q - TR_W'(1);
    end else begin
      trig_nxt = trig_q;
    end
  end

  // The whole bus is built from next-state values so every bit comes straight out of a flop.
  always_comb begin
    gpio_nxt    = lvl_nxt;
    gpio_nxt[6] = (trig_nxt != '0);
    if (state_nxt == SETUP || state_nxt == HIGH) begin
      gpio_nxt[0] = word_nxt[idx_nxt[IDX_W-1:0]];
    end
    if (state_nxt == HIGH) begin
      gpio_nxt[sel_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      sel_q    <= '0;
      trig_q   <= '0;
      lvl_q    <= '0;
      ready_q  <= 1'b0;
      err      <= 1'b0;
      gpio_out <= '0;
    end else begin
      state_q  <= state_nxt;
      ph_q     <= ph_nxt;
      idx_q    <= idx_nxt;
      word_q   <= word_nxt;
      sel_q    <= sel_nxt;
      trig_q   <= trig_nxt;
      lvl_q    <= lvl_nxt;
      ready_q  <= (state_nxt == IDLE);
      err      <= err_nxt;
      gpio_out <= gpio_nxt;
    end
  end

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
module tb_gpio_cfg_serializer;

  localparam int GPIO_W = 16;
  localparam int DATA_W = 32;
  localparam int HALF   = 2;
  localparam int TRIGC  = 4;
  localparam logic [15:0] CLK_MASK = 16'h1F9E;  // bits 1-4, 7-12

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [7:0]        cmd_sel = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [5:0]        cmd_nbits = '0;
  logic              lvl_we = 1'b0;
  logic [GPIO_W-1:0] lvl_data = '0;
  logic              trig_req = 1'b0;
  logic [GPIO_W-1:0] gpio_out;
  logic              busy;
  logic              err;

  gpio_cfg_serializer #(.GPIO_W(GPIO_W), .DATA_W(DATA_W), .HALF(HALF), .TRIG_CYCLES(TRIGC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_data(cmd_data), .cmd_nbits(cmd_nbits), .lvl_we(lvl_we), .lvl_data(lvl_data),
    .trig_req(trig_req), .gpio_out(gpio_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int   kind;  // 0 = clock rising edge, 1 = err pulse
    int   sel;
    logic b;
    int   cyc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; n_exp rising edges (first bits) are queued, or an err pulse if exp_err.
  task automatic send(input int sel, input int nb, input logic [31:0] d,
                      input int n_exp, input bit exp_err, output int e);
    int n = 0;
    while (!cmd_ready && n < 300) begin tick(); n++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_sel   = 8'(sel);
    cmd_nbits = 6'(nb);
    cmd_data  = d;
    e = cyc + 1;
    if (exp_err) q.push_back('{1, 0, 1'b0, e});
    for (int k = 0; k < n_exp; k++)
      q.push_back('{0, sel, d[nb-1-k], e + HALF + 2*HALF*k});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !cmd_ready) && n < 500) begin tick(); n++; end
    if (n >= 500) chk("idle_timeout", 0, 1);
  endtask

  // Monitor: every rising clock-line edge and every err pulse consumes one expected entry.
  logic [15:0] prev_gpio = '0;
  logic [15:0] rises;
  exp_t        m_e;
  always @(negedge clk) begin
    rises = gpio_out & ~prev_gpio & CLK_MASK;
    if (rises != 16'h0) begin
      if (q.size() == 0) chk("spurious_edge", rises, 0);
      else begin
        m_e = q.pop_front();
        chk("edge_kind", m_e.kind, 0);
        chk("edge_line", rises, 16'h1 << m_e.sel);
        chk("edge_sdata", gpio_out[0], m_e.b);
        chk("edge_cycle", cyc, m_e.cyc);
      end
    end
    if (err) begin
      if (q.size() == 0) chk("spurious_err", 1, 0);
      else begin
        m_e = q.pop_front();
        chk("err_kind", m_e.kind, 1);
        chk("err_cycle", cyc, m_e.cyc);
      end
    end
    prev_gpio = gpio_out;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, cnt, bad;
    logic [8:0] obs;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_gpio", gpio_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    tick();

    // sel 3, 8 bits, 0xA5: bits 1,0,1,0,0,1,0,1
    send(3, 8, 32'hA5, 8, 1'b0, e);
    cnt = 0; bad = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if ((gpio_out & ~16'h0009) != 16'h0) bad++;
    end
    chk("a5_busy_cycles", cnt, 33);
    chk("a5_other_bits", bad, 0);
    chk("a5_ready_back", cmd_ready, 1);
    chk("a5_ready_cycle", cyc, e + 33);
    tick();

    // Rejections: level line, nbits 0, nbits 33, index 0
    send(5, 8, 32'hFF, 0, 1'b1, e);
    send(3, 0, 32'hFF, 0, 1'b1, e);
    send(2, 33, 32'hFF, 0, 1'b1, e);
    send(0, 4, 32'hFF, 0, 1'b1, e);
    @(negedge clk);
    chk("rej_ready", cmd_ready, 1);
    chk("rej_busy", busy, 0);
    chk("rej_gpio", gpio_out, 0);
    tick();
    tick();

    // Full-width word on line 12
    send(12, 32, 32'h80000001, 32, 1'b0, e);
    wait_idle();
    tick();

    // Trigger at "cycle 10" and again two cycles later -> 6-cycle pulse
    for (int i = 0; i < 9; i++) begin
      trig_req = (i == 0 || i == 2);
      @(negedge clk);
      obs[i] = gpio_out[6];
      tick();
    end
    trig_req = 1'b0;
    chk("trig_window", obs, 9'h07E);

    // Level write in the middle of a shift on line 7
    send(7, 4, 32'h9, 4, 1'b0, e);
    repeat (5) tick();
    lvl_we   = 1'b1;
    lvl_data = 16'hFFFF;
    tick();
    lvl_we = 1'b0;
    @(negedge clk);
    chk("lvl_mid_shift", gpio_out & ~16'h0081, 16'hE020);
    wait_idle();
    tick();

    // Level write, trigger and accept in the same cycle
    lvl_we   = 1'b1;
    lvl_data = 16'h2000;
    trig_req = 1'b1;
    send(1, 2, 32'h2, 2, 1'b0, e);
    lvl_we   = 1'b0;
    trig_req = 1'b0;
    @(negedge clk);
    chk("simul_gpio", gpio_out, 16'h2041);
    wait_idle();
    tick();

    // Reset during the third bit of 0xC3 on line 4: only bits 1,1 get clocked
    send(4, 8, 32'hC3, 2, 1'b0, e);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_gpio", gpio_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("postrst_ready", cmd_ready, 1);
    tick();
    send(2, 3, 32'h3, 3, 1'b0, e);
    wait_idle();
    repeat (4) tick();
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
